// File: rtl/lane_xnor_pipe.sv
// Per-lane f = a XNOR ((~c & (b ^ d)) | (~b & ~d)) carried through a DEPTH-stage valid/ready pipeline.
// Define LANE_XNOR_TOGGLE_MON_EN to build the output toggle/handshake monitor (counters read 0 otherwise).
module lane_xnor_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             mon_clear,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [WIDTH-1:0]            f;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            src_v;
  logic [DEPTH-1:0][WIDTH-1:0] src_data;
  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;

  always_comb begin
    f = ~(in_a ^ ((~in_c & (in_b ^ in_d)) | (~in_b & ~in_d)));
  end

  // A stage may advance when the stage after it advances or when it holds no beat.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = out_ready | ~v_q[DEPTH-1];
    for (int unsigned i = 1; i < DEPTH; i++) begin
      adv[DEPTH-1-i] = adv[DEPTH-i] | ~v_q[DEPTH-1-i];
    end
  end

  always_comb begin
    src_v       = '0;
    src_data    = '0;
    src_v[0]    = in_valid;
    src_data[0] = f;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      src_v[k]    = v_q[k-1];
      src_data[k] = data_q[k-1];
    end
  end

  // Data only loads behind a valid beat; a bubble clears the valid bit but keeps old data.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (adv[k]) begin
        v_d[k] = src_v[k];
        if (src_v[k]) begin
          data_d[k] = src_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

`ifdef LANE_XNOR_TOGGLE_MON_EN
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_hs;
  logic [WIDTH-1:0] diff;
  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] tog_sum, xfer_sum;
  logic [WIDTH-1:0] last_q, last_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;

  always_comb begin
    out_hs = out_valid & out_ready;
    diff   = out_data ^ last_q;
    pop    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + PC_W'(diff[i]);
    end
    tog_sum  = SUM_W'(tog_q) + SUM_W'(pop);
    xfer_sum = SUM_W'(xfer_q) + SUM_W'(1);
    tog_d    = tog_q;
    xfer_d   = xfer_q;
    last_d   = last_q;
    if (out_hs) begin
      tog_d  = (tog_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : tog_sum[CNT_W-1:0];
      xfer_d = (xfer_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : xfer_sum[CNT_W-1:0];
      last_d = out_data;
    end
    // Clear beats a same-cycle increment; last_out still tracks a concurrent handshake.
    if (mon_clear) begin
      tog_d  = '0;
      xfer_d = '0;
      if (!out_hs) begin
        last_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      tog_q  <= '0;
      xfer_q <= '0;
    end else begin
      last_q <= last_d;
      tog_q  <= tog_d;
      xfer_q <= xfer_d;
    end
  end

  assign toggle_cnt = tog_q;
  assign xfer_cnt   = xfer_q;
`else
  logic unused_mon_clear;
  assign unused_mon_clear = mon_clear;
  assign toggle_cnt = '0;
  assign xfer_cnt   = '0;
`endif

endmodule
